m_dmem: RTL and testbench

M_DMEM -- requirements
Module: m_dmem

---
 rtl/m_dmem.sv | 93 +++++++++
 tb/tb_m_dmem.sv | 131 +++++++++++++
 2 files changed

// File: rtl/m_dmem.sv
// m_dmem: 32-bit data memory with request/response handshake, configurable latency, and optional misalignment errors when DMEM_MISALIGN_ERR_EN is defined
module m_dmem #(
    parameter int DEPTH_LOG2 = 6,
    parameter int LATENCY    = 1
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    input  logic        w_req_valid,
    output logic        w_req_ready,
    input  logic        w_req_we,
    input  logic [31:0] w_req_addr,
    input  logic [1:0]  w_req_size,
    input  logic        w_req_unsigned,
    input  logic [31:0] w_req_wdata,
    output logic        w_rsp_valid,
    input  logic        w_rsp_ready,
    output logic [31:0] w_rsp_rdata,
    output logic        w_rsp_err
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_nxt;
    logic [3:0] cnt;
    logic op_we, op_uns, mis, access, is_byte, is_half;
    logic [DEPTH_LOG2+1:0] op_addr;
    logic [1:0] op_size;
    logic [31:0] op_wdata, word, shifted, ld, mask, wd, nw;
    logic [15:0] half;
    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0] mem [2**DEPTH_LOG2] = '{default: '0};
    logic addr_unused;
    assign addr_unused = ^w_req_addr[31:DEPTH_LOG2+2];
    assign w_req_ready = state == IDLE;
    assign w_rsp_valid = state == RESP;
    assign access = state == WAIT && cnt == 4'd0;
    assign idx = op_addr[DEPTH_LOG2+1:2];
    assign word = mem[idx];
    assign is_byte = op_size == 2'b00;
    assign is_half = op_size == 2'b01;
`ifdef DMEM_MISALIGN_ERR_EN
    assign mis = (is_half && op_addr[0]) || (op_size[1] && op_addr[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif
    // Without error checking, the low offset bits of halves and words are simply ignored
    assign shifted = word >> {op_addr[1:0], 3'b000};
    assign half = op_addr[1] ? word[31:16] : word[15:0];
    assign ld = is_byte ? {{24{~op_uns & shifted[7]}}, shifted[7:0]} :
                is_half ? {{16{~op_uns & half[15]}}, half} : word;
    assign mask = is_byte ? 32'hFF << {op_addr[1:0], 3'b000} :
                  is_half ? (op_addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF) : 32'hFFFF_FFFF;
    assign wd = is_byte ? {4{op_wdata[7:0]}} : is_half ? {2{op_wdata[15:0]}} : op_wdata;
    assign nw = (word & ~mask) | (wd & mask);
    always_ff @(posedge w_clk)
        if (access && op_we && !mis) mem[idx] <= nw;
    always_ff @(posedge w_clk or negedge w_rst_n)
        if (!w_rst_n) state <= IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = w_req_valid ? WAIT : IDLE;
            WAIT: state_nxt = cnt == 4'd0 ? RESP : WAIT;
            RESP: state_nxt = w_rsp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge w_clk or negedge w_rst_n)
        if (!w_rst_n) begin
            cnt <= 4'd0;
            w_rsp_rdata <= 32'd0;
            w_rsp_err <= 1'b0;
            op_we <= 1'b0;
            op_uns <= 1'b0;
            op_addr <= '0;
            op_size <= 2'b00;
            op_wdata <= 32'd0;
        end else begin
            if (state == IDLE && w_req_valid) begin
                cnt <= 4'(LATENCY);
                op_we <= w_req_we;
                op_uns <= w_req_unsigned;
                op_addr <= w_req_addr[DEPTH_LOG2+1:0];
                op_size <= w_req_size;
                op_wdata <= w_req_wdata;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                w_rsp_rdata <= (op_we || mis) ? 32'd0 : ld;
                w_rsp_err <= mis;
            end
        end
endmodule

// File: tb/tb_m_dmem.sv
// tb_m_dmem: directed checks of m_dmem with LATENCY=1 and LATENCY=4 instances
module tb_m_dmem;
`ifdef DMEM_MISALIGN_ERR_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0, sel = 1'b0;
    logic req_valid = 1'b0, req_we = 1'b0, req_uns = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [1:0] req_size = 2'b10;
    logic rdy [2], vld [2], er [2];
    logic [31:0] rd [2];
    logic [31:0] r_rd;
    logic r_er;
    int passed = 0, fails = 0, total = 0;

    always #5 clk = ~clk;

    m_dmem #(.DEPTH_LOG2(6), .LATENCY(1)) dut1 (
        .w_clk(clk), .w_rst_n(rst_n), .w_req_valid(req_valid && !sel), .w_req_ready(rdy[0]),
        .w_req_we(req_we), .w_req_addr(req_addr), .w_req_size(req_size), .w_req_unsigned(req_uns),
        .w_req_wdata(req_wdata), .w_rsp_valid(vld[0]), .w_rsp_ready(rsp_ready && !sel),
        .w_rsp_rdata(rd[0]), .w_rsp_err(er[0]));
    m_dmem #(.DEPTH_LOG2(6), .LATENCY(4)) dut4 (
        .w_clk(clk), .w_rst_n(rst_n), .w_req_valid(req_valid && sel), .w_req_ready(rdy[1]),
        .w_req_we(req_we), .w_req_addr(req_addr), .w_req_size(req_size), .w_req_unsigned(req_uns),
        .w_req_wdata(req_wdata), .w_rsp_valid(vld[1]), .w_rsp_ready(rsp_ready && sel),
        .w_rsp_rdata(rd[1]), .w_rsp_err(er[1]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full transaction: accept, measure edges to response, optionally stall, then handshake
    task automatic xfer(input string tag, input bit s, input bit we, input logic [31:0] a,
                        input logic [1:0] sz, input bit u, input logic [31:0] wdat, input int hold,
                        input int exp_lat, input logic [31:0] exp_rd, input logic exp_er);
        int n;
        @(negedge clk);
        sel = s; req_we = we; req_addr = a; req_size = sz; req_uns = u; req_wdata = wdat;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (!vld[sel] && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        req_we = 1'b1; req_wdata = 32'd0; req_valid = hold > 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_valid"}, 32'(vld[sel]), 32'd1);
            chk({tag, "_hold_rdata"}, rd[sel], exp_rd);
            chk({tag, "_hold_ready"}, 32'(rdy[sel]), 32'd0);
        end
        req_valid = 1'b0;
        r_rd = rd[sel];
        r_er = er[sel];
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        chk({tag, "_rdata"}, r_rd, exp_rd);
        chk({tag, "_err"}, 32'(r_er), 32'(exp_er));
        chk({tag, "_post_valid"}, 32'(vld[sel]), 32'd0);
        chk({tag, "_post_ready"}, 32'(rdy[sel]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #2;
        chk("rst_valid", 32'(vld[0]), 32'd0);
        chk("rst_ready", 32'(rdy[0]), 32'd1);
        chk("rst_rdata", rd[0], 32'd0);
        chk("rst_err", 32'(er[0]), 32'd0);
        chk("rst_valid4", 32'(vld[1]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        xfer("st_word", 0, 1, 32'h10, 2'b10, 0, 32'hDEADBEEF, 0, 2, 32'd0, 1'b0);
        xfer("ld_word", 0, 0, 32'h10, 2'b10, 0, 32'd0, 0, 2, 32'hDEADBEEF, 1'b0);
        xfer("st_base", 0, 1, 32'h10, 2'b10, 0, 32'h11223344, 0, 2, 32'd0, 1'b0);
        xfer("st_byte", 0, 1, 32'h13, 2'b00, 0, 32'h12345680, 0, 2, 32'd0, 1'b0);
        xfer("ld_bs", 0, 0, 32'h13, 2'b00, 0, 32'd0, 0, 2, 32'hFFFFFF80, 1'b0);
        xfer("ld_bu", 0, 0, 32'h13, 2'b00, 1, 32'd0, 0, 2, 32'h00000080, 1'b0);
        xfer("ld_merged", 0, 0, 32'h10, 2'b10, 0, 32'd0, 0, 2, 32'h80223344, 1'b0);
        xfer("stall", 0, 0, 32'h10, 2'b10, 0, 32'd0, 5, 2, 32'h80223344, 1'b0);
        xfer("ld_ignored", 0, 0, 32'h10, 2'b10, 0, 32'd0, 0, 2, 32'h80223344, 1'b0);
        xfer("ld_hs", 0, 0, 32'h12, 2'b01, 0, 32'd0, 0, 2, 32'hFFFF8022, 1'b0);
        xfer("ld_hu", 0, 0, 32'h12, 2'b01, 1, 32'd0, 0, 2, 32'h00008022, 1'b0);
        xfer("st_wrap", 0, 1, 32'h100, 2'b10, 0, 32'h5A, 0, 2, 32'd0, 1'b0);
        xfer("ld_wrap", 0, 0, 32'h000, 2'b10, 0, 32'd0, 0, 2, 32'h5A, 1'b0);
        xfer("st_half", 0, 1, 32'h000, 2'b01, 0, 32'h1234BEEF, 0, 2, 32'd0, 1'b0);
        xfer("ld_half_w", 0, 0, 32'h000, 2'b10, 0, 32'd0, 0, 2, 32'h0000BEEF, 1'b0);
        xfer("st_mis", 0, 1, 32'h22, 2'b10, 0, 32'hCAFEF00D, 0, 2, 32'd0, MIS);
        xfer("ld_mis_chk", 0, 0, 32'h20, 2'b10, 0, 32'd0, 0, 2, MIS ? 32'd0 : 32'hCAFEF00D, 1'b0);
        xfer("st4_old", 1, 1, 32'h8, 2'b10, 0, 32'h11, 0, 5, 32'd0, 1'b0);
        @(negedge clk);
        sel = 1'b1; req_we = 1'b1; req_addr = 32'h8; req_size = 2'b10; req_wdata = 32'h77;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("wait_busy", 32'(rdy[1]), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(vld[1]), 32'd0);
        chk("midrst_ready", 32'(rdy[1]), 32'd1);
        chk("midrst_rdata", rd[1], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("after_rst_valid", 32'(vld[1]), 32'd0);
        xfer("ld4_old", 1, 0, 32'h8, 2'b10, 0, 32'd0, 0, 5, 32'h11, 1'b0);
        xfer("ld_keep", 0, 0, 32'h10, 2'b10, 0, 32'd0, 0, 2, 32'h80223344, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
